// File: rtl/tff_counter_pkg.sv
// tff_counter_pkg: shared direction constants and width helper for tff_counter users.
package tff_counter_pkg;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  function automatic int unsigned width_for(input int unsigned modulo);
    return (modulo <= 2) ? 1 : $clog2(modulo);
  endfunction
endpackage

// File: rtl/tff_counter_if.sv
// tff_counter_if: control inputs and status outputs of one counter digit.
interface tff_counter_if #(parameter int WIDTH = 4);
  logic en;
  logic up;
  logic load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic tc;
  logic wrap;
  logic load_err;
  modport master (output en, up, load, D, input Q, tc, wrap, load_err);
  modport slave (input en, up, load, D, output Q, tc, wrap, load_err);
endinterface

// File: rtl/tff_counter_cell.sv
// tff_cell: single-bit T flip-flop with synchronous reset to a per-bit value.
module tff_cell (
  input  logic Clk,
  input  logic rst,
  input  logic rst_val,
  input  logic T,
  output logic Q
);
  always_ff @(posedge Clk)
    if (rst) Q <= rst_val;
    else Q <= Q ^ T;
endmodule

// File: rtl/tff_counter.sv
// tff_counter: up/down modulo counter built from T cells, with load, tc, wrap and load_err.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODULO = 10,
  parameter int RESET_VAL = 0
) (
  input logic Clk,
  input logic rst,
  tff_counter_if.slave bus
);
  if (WIDTH < 1 || MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad
    $fatal(1, "tff_counter: illegal WIDTH/MODULO/RESET_VAL");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] q, q_d;
  logic at_max, at_zero, at_end, load_ok, wrap_d, load_err_d, wrap_q, load_err_q;
  always_comb begin
    at_max = q == MAX;
    at_zero = q == '0;
    at_end = bus.up == DIR_UP ? at_max : at_zero;
    load_ok = bus.D <= MAX;
    q_d = bus.load ? (load_ok ? bus.D : MAX)
        : !bus.en ? q
        : bus.up == DIR_UP ? (at_max ? '0 : q + 1'b1)
        : (at_zero ? MAX : q - 1'b1);
    wrap_d = !bus.load && bus.en && at_end;
    load_err_d = bus.load && !load_ok;
  end
  // each cell toggles exactly the bits that differ from the next value
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (.Clk(Clk), .rst(rst), .rst_val(RST[g]), .T(q[g] ^ q_d[g]), .Q(q[g]));
  end
  always_ff @(posedge Clk)
    if (rst) begin
      wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      load_err_q <= load_err_d;
    end
  assign bus.Q = q;
  assign bus.tc = bus.en && at_end;
  assign bus.wrap = wrap_q;
  assign bus.load_err = load_err_q;
endmodule
